inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter RESET_PC SHALL be declared as: RESET_PC, 32'h00000000, byte address loaded into the PC on reset.
REQ-003 Port clk SHALL be declared as: clk  in  1  rising-edge clock.
REQ-004 Port rst SHALL be declared as: rst  in  1  asynchronous active-high reset.
REQ-005 Port stall SHALL be declared as: stall  in  1  hold PC and IF/ID register (load-use hazard).
REQ-006 Port flush SHALL be declared as: flush  in  1  insert bubble into IF/ID.
REQ-007 Port redirect SHALL be declared as: redirect  in  1  load PC from redirect_pc (taken branch from a later stage).
REQ-008 Port redirect_pc SHALL be declared as: redirect_pc  in  32  branch/jump target byte address.
REQ-009 Port rom_addr SHALL be declared as: rom_addr  out  32  byte address to the instruction ROM; the ROM indexes words with bits [7:2].
REQ-010 Port rom_inst SHALL be declared as: rom_inst  in  32  combinational instruction word returned by the ROM.
REQ-011 Port id_inst SHALL be declared as: id_inst  out  32  registered instruction to decode.
REQ-012 Port id_pc SHALL be declared as: id_pc  out  32  registered address of id_inst.
REQ-013 Port id_pc4 SHALL be declared as: id_pc4  out  32  registered id_pc+4.
REQ-014 Port id_valid SHALL be declared as: id_valid  out  1  IF/ID slot holds a real instruction.
REQ-015 Port id_jump_taken SHALL be declared as: id_jump_taken  out  1  id_inst was a j already resolved in fetch.

Function
REQ-016 rom_addr SHALL equal the internal pc register combinationally, with zero added latency; fetch-to-ID latency SHALL be one clock.
REQ-017 Next-state priority SHALL be: redirect > stall > sequential.
REQ-018 On redirect=1, pc SHALL load {redirect_pc[31:2],2'b00}; IF/ID SHALL load a bubble (id_valid=0, id_inst=0, id_jump_taken=0); this applies regardless of stall and flush.
REQ-019 On stall=1 without redirect, pc SHALL hold; IF/ID SHALL hold unless flush=1, in which case IF/ID SHALL load a bubble.
REQ-020 With no redirect and no stall: pc <= next_pc; id_inst <= rom_inst; id_pc <= pc; id_pc4 <= pc+4; id_valid <= ~flush.
REQ-021 next_pc SHALL be pc+4 (modulo 2^32, wraps 0xFFFFFFFC->0x00000000) unless REQ-029 applies.
REQ-022 When a bubble is loaded, id_pc and id_pc4 SHALL still capture pc and pc+4.
REQ-023 An all-zero rom_inst SHALL pass through as a normal instruction (id_valid=1); the module SHALL NOT interpret it.
REQ-024 Simultaneous flush and stall: pc SHALL hold and IF/ID SHALL become a bubble.

Reset
REQ-025 Asserting rst SHALL immediately, independent of clk, set pc=RESET_PC, id_inst=0, id_pc=0, id_pc4=0, id_valid=0, id_jump_taken=0, including mid-operation (stall, redirect or jump in progress).
REQ-026 The first rising edge after rst deasserts SHALL capture rom_inst at RESET_PC, giving id_valid=1 one clock later.
REQ-027 Every output SHALL be driven and deterministic while rst=1; rom_addr SHALL equal RESET_PC while rst=1.

Configuration
REQ-028 Macro INST_FETCH_JUMP_DECODE_EN SHALL select early jump resolution in fetch.
REQ-029 With INST_FETCH_JUMP_DECODE_EN defined: if rom_inst[31:26]==6'h12 (j) and there is no redirect and no stall, then next_pc SHALL be {pc[31:28], rom_inst[25:0], 2'b00} and id_jump_taken SHALL be 1 with that instruction (id_valid=1). If flush is also 1, the jump SHALL still redirect the PC, and id_valid and id_jump_taken SHALL be 0.
REQ-030 With INST_FETCH_JUMP_DECODE_EN undefined: next_pc SHALL always be pc+4, id_jump_taken SHALL be constant 0, and no opcode decode logic SHALL exist.

Verification
REQ-031 Reset release with RESET_PC=0 and the ROM holding 0x00100443, 0x00201025, 0x04101881 -> after edges 1/2/3: id_pc = 0x0/0x4/0x8, id_inst matches each word in order, id_valid=1.
REQ-032 stall=1 for 2 cycles at pc=0x8 -> rom_addr=0x8 and id_inst/id_pc frozen for 2 cycles; the fetch sequence resumes at 0x8 with no instruction lost or duplicated.
REQ-033 redirect=1, redirect_pc=0x1E, with stall=1 in the same cycle -> next rom_addr=0x1C, id_valid=0, id_inst=0.
REQ-034 pc=0x38 with rom_inst=0x48000014 -> with the macro: next rom_addr=0x50, id_jump_taken=1; without the macro: next rom_addr=0x3C, id_jump_taken=0.
REQ-035 rst pulsed asynchronously between clock edges while pc=0x24 and id_valid=1 -> outputs reset before the next edge, rom_addr=0x0.
REQ-036 flush=1 alone at pc=0x10 -> id_valid=0, id_pc=0x10, next rom_addr=0x14.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: pipeline control in, ROM address/data, and the IF/ID register outputs.
// The fetch unit takes the slave side; the surrounding pipeline (or a bench) takes the master side.
interface inst_fetch_if;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        id_jump_taken;

    modport slave (
        input  stall,
        input  flush,
        input  redirect,
        input  redirect_pc,
        output rom_addr,
        input  rom_inst,
        output id_inst,
        output id_pc,
        output id_pc4,
        output id_valid,
        output id_jump_taken
    );

    modport master (
        output stall,
        output flush,
        output redirect,
        output redirect_pc,
        input  rom_addr,
        output rom_inst,
        input  id_inst,
        input  id_pc,
        input  id_pc4,
        input  id_valid,
        input  id_jump_taken
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, sequential/redirect next-PC selection and the IF/ID register.
// Define INST_FETCH_JUMP_DECODE_EN to resolve 'j' (opcode 6'h12) in fetch instead of waiting for a redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.slave  bus
);

    logic [31:0] r_pc;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic [31:0] w_pc4;
    logic [31:0] w_redirect_target;
    logic [31:0] w_next_pc;

    assign w_pc4             = r_pc + 32'd4;
    assign w_redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef INST_FETCH_JUMP_DECODE_EN
    logic        r_id_jump_taken;
    logic        w_is_jump;
    logic [31:0] w_jump_target;

    assign w_is_jump     = (bus.rom_inst[31:26] == 6'h12);
    assign w_jump_target = {r_pc[31:28], bus.rom_inst[25:0], 2'b00};
    assign w_next_pc     = w_is_jump ? w_jump_target : w_pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_jump_taken <= 1'b0;
        end else if (bus.redirect) begin
            r_id_jump_taken <= 1'b0;
        end else if (bus.stall) begin
            if (bus.flush) begin
                r_id_jump_taken <= 1'b0;
            end
        end else begin
            // A flushed jump still steers the PC, but the slot is not reported as a taken jump.
            r_id_jump_taken <= w_is_jump & ~bus.flush;
        end
    end

    assign bus.id_jump_taken = r_id_jump_taken;
`else
    assign w_next_pc         = w_pc4;
    assign bus.id_jump_taken = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_id_inst  <= 32'h0;
            r_id_pc    <= 32'h0;
            r_id_pc4   <= 32'h0;
            r_id_valid <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect overrides stall and flush: whatever sits in fetch is on the wrong path.
            r_pc       <= w_redirect_target;
            r_id_inst  <= 32'h0;
            r_id_pc    <= r_pc;
            r_id_pc4   <= w_pc4;
            r_id_valid <= 1'b0;
        end else if (bus.stall) begin
            if (bus.flush) begin
                r_id_inst  <= 32'h0;
                r_id_pc    <= r_pc;
                r_id_pc4   <= w_pc4;
                r_id_valid <= 1'b0;
            end
        end else begin
            r_pc       <= w_next_pc;
            r_id_inst  <= bus.rom_inst;
            r_id_pc    <= r_pc;
            r_id_pc4   <= w_pc4;
            r_id_valid <= ~bus.flush;
        end
    end

    assign bus.rom_addr = r_pc;
    assign bus.id_inst  = r_id_inst;
    assign bus.id_pc    = r_id_pc;
    assign bus.id_pc4   = r_id_pc4;
    assign bus.id_valid = r_id_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, sequential fetch, stall, redirect, flush, jump, wrap, async reset.
module tb_inst_fetch;

    logic clk;
    logic rst;
    logic [31:0] rom [0:63];
    int total;
    int bad;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(32'h00000000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_inst = rom[bus.rom_addr[7:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        step();
        bus.redirect    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_inst [0:2];
        exp_inst[0] = 32'h00100443;
        exp_inst[1] = 32'h00201025;
        exp_inst[2] = 32'h04101881;
        step();
        total++;
        if (bus.rom_addr !== 32'h0) begin bad++; $display("FAIL reset_rom_addr got=%h exp=%h", bus.rom_addr, 32'h0); end
        total++;
        if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
        total++;
        if (bus.id_inst !== 32'h0 || bus.id_pc !== 32'h0 || bus.id_pc4 !== 32'h0)
            begin bad++; $display("FAIL reset_id_regs got inst=%h pc=%h pc4=%h exp all 0", bus.id_inst, bus.id_pc, bus.id_pc4); end
        total++;
        if (bus.id_jump_taken !== 1'b0) begin bad++; $display("FAIL reset_jump got=%b exp=0", bus.id_jump_taken); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.id_pc !== 32'(i * 4) || bus.id_inst !== exp_inst[i] || bus.id_valid !== 1'b1 || bus.id_pc4 !== 32'(i * 4 + 4))
                begin bad++; $display("FAIL seq_edge%0d got pc=%h inst=%h v=%b pc4=%h exp pc=%h inst=%h v=1 pc4=%h",
                    i + 1, bus.id_pc, bus.id_inst, bus.id_valid, bus.id_pc4, 32'(i * 4), exp_inst[i], 32'(i * 4 + 4)); end
        end
        $display("reset+seq: rom_addr=%h id_pc=%h", bus.rom_addr, bus.id_pc);
    endtask

    task automatic test_stall();
        redirect_to(32'h4);
        total++;
        if (bus.rom_addr !== 32'h4 || bus.id_valid !== 1'b0 || bus.id_pc !== 32'hC)
            begin bad++; $display("FAIL redir4 got addr=%h v=%b pc=%h exp addr=4 v=0 pc=c", bus.rom_addr, bus.id_valid, bus.id_pc); end
        step();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (bus.rom_addr !== 32'h8 || bus.id_pc !== 32'h4 || bus.id_inst !== 32'h00201025 || bus.id_valid !== 1'b1)
                begin bad++; $display("FAIL stall_c%0d got addr=%h pc=%h inst=%h v=%b exp addr=8 pc=4 inst=00201025 v=1",
                    i, bus.rom_addr, bus.id_pc, bus.id_inst, bus.id_valid); end
        end
        bus.stall = 1'b0;
        step();
        total++;
        if (bus.id_pc !== 32'h8 || bus.id_inst !== 32'h04101881 || bus.id_valid !== 1'b1)
            begin bad++; $display("FAIL stall_resume0 got pc=%h inst=%h v=%b exp pc=8 inst=04101881 v=1", bus.id_pc, bus.id_inst, bus.id_valid); end
        step();
        total++;
        if (bus.id_pc !== 32'hC || bus.id_inst !== 32'h10000003)
            begin bad++; $display("FAIL stall_resume1 got pc=%h inst=%h exp pc=c inst=10000003", bus.id_pc, bus.id_inst); end
        $display("stall: rom_addr=%h id_pc=%h", bus.rom_addr, bus.id_pc);
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1'b1;
        redirect_to(32'h1E);
        bus.stall = 1'b0;
        total++;
        if (bus.rom_addr !== 32'h1C) begin bad++; $display("FAIL redir_stall_addr got=%h exp=0000001c", bus.rom_addr); end
        total++;
        if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.id_jump_taken !== 1'b0)
            begin bad++; $display("FAIL redir_stall_bubble got v=%b inst=%h j=%b exp 0/0/0", bus.id_valid, bus.id_inst, bus.id_jump_taken); end
        total++;
        if (bus.id_pc !== 32'h10 || bus.id_pc4 !== 32'h14)
            begin bad++; $display("FAIL redir_stall_pc got pc=%h pc4=%h exp 10/14", bus.id_pc, bus.id_pc4); end
        $display("redirect+stall: rom_addr=%h", bus.rom_addr);
    endtask

    task automatic test_flush();
        redirect_to(32'h10);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total++;
        if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h10 || bus.id_pc4 !== 32'h14 || bus.rom_addr !== 32'h14)
            begin bad++; $display("FAIL flush got v=%b pc=%h pc4=%h addr=%h exp 0/10/14/14", bus.id_valid, bus.id_pc, bus.id_pc4, bus.rom_addr); end
        step();
        total++;
        if (bus.id_valid !== 1'b1 || bus.id_inst !== 32'h0 || bus.id_pc !== 32'h14)
            begin bad++; $display("FAIL zero_inst got v=%b inst=%h pc=%h exp 1/0/14", bus.id_valid, bus.id_inst, bus.id_pc); end
        $display("flush: rom_addr=%h", bus.rom_addr);
    endtask

    task automatic test_flush_stall();
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        total++;
        if (bus.rom_addr !== 32'h18 || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.id_pc !== 32'h18)
            begin bad++; $display("FAIL flush_stall got addr=%h v=%b inst=%h pc=%h exp 18/0/0/18",
                bus.rom_addr, bus.id_valid, bus.id_inst, bus.id_pc); end
        $display("flush+stall: rom_addr=%h", bus.rom_addr);
    endtask

    task automatic test_jump();
        logic [31:0] exp_addr;
        logic        exp_j;
`ifdef INST_FETCH_JUMP_DECODE_EN
        exp_addr = 32'h50;
        exp_j    = 1'b1;
`else
        exp_addr = 32'h3C;
        exp_j    = 1'b0;
`endif
        redirect_to(32'h38);
        step();
        total++;
        if (bus.rom_addr !== exp_addr || bus.id_jump_taken !== exp_j)
            begin bad++; $display("FAIL jump got addr=%h j=%b exp addr=%h j=%b", bus.rom_addr, bus.id_jump_taken, exp_addr, exp_j); end
        total++;
        if (bus.id_inst !== 32'h48000014 || bus.id_valid !== 1'b1 || bus.id_pc !== 32'h38)
            begin bad++; $display("FAIL jump_slot got inst=%h v=%b pc=%h exp 48000014/1/38", bus.id_inst, bus.id_valid, bus.id_pc); end
        redirect_to(32'h38);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total++;
        if (bus.rom_addr !== exp_addr || bus.id_valid !== 1'b0 || bus.id_jump_taken !== 1'b0)
            begin bad++; $display("FAIL jump_flush got addr=%h v=%b j=%b exp addr=%h v=0 j=0", bus.rom_addr, bus.id_valid, bus.id_jump_taken, exp_addr); end
        $display("jump: rom_addr=%h", bus.rom_addr);
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFFFFFC);
        step();
        total++;
        if (bus.rom_addr !== 32'h0 || bus.id_pc !== 32'hFFFFFFFC || bus.id_pc4 !== 32'h0 || bus.id_inst !== 32'h1000003F)
            begin bad++; $display("FAIL wrap got addr=%h pc=%h pc4=%h inst=%h exp 0/fffffffc/0/1000003f",
                bus.rom_addr, bus.id_pc, bus.id_pc4, bus.id_inst); end
        $display("wrap: rom_addr=%h", bus.rom_addr);
    endtask

    task automatic test_async_reset();
        redirect_to(32'h20);
        step();
        total++;
        if (bus.rom_addr !== 32'h24 || bus.id_valid !== 1'b1 || bus.id_pc !== 32'h20)
            begin bad++; $display("FAIL areset_pre got addr=%h v=%b pc=%h exp 24/1/20", bus.rom_addr, bus.id_valid, bus.id_pc); end
        bus.stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.rom_addr !== 32'h0 || bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 || bus.id_pc4 !== 32'h0)
            begin bad++; $display("FAIL areset got addr=%h v=%b pc=%h inst=%h pc4=%h exp all 0",
                bus.rom_addr, bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4); end
        #1;
        rst = 1'b0;
        bus.stall = 1'b0;
        step();
        total++;
        if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h00100443 || bus.id_valid !== 1'b1)
            begin bad++; $display("FAIL areset_release got pc=%h inst=%h v=%b exp 0/00100443/1", bus.id_pc, bus.id_inst, bus.id_valid); end
        $display("async reset: rom_addr=%h", bus.rom_addr);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h10000000 + 32'(i);
        rom[0]  = 32'h00100443;
        rom[1]  = 32'h00201025;
        rom[2]  = 32'h04101881;
        rom[5]  = 32'h00000000;
        rom[14] = 32'h48000014;
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        test_reset();
        test_stall();
        test_redirect_stall();
        test_flush();
        test_flush_stall();
        test_jump();
        test_wrap();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
